// File: rtl/hd_timing_pkg.sv
// 720p raster constants, genlock state type and a 13-bit sum helper shared by the timing generator.
// Pure definitions: no latency, no flow control.
package hd_timing_pkg;

    localparam int HD720_H_ACTIVE = 1280;
    localparam int HD720_H_FP     = 110;
    localparam int HD720_H_SYNC   = 40;
    localparam int HD720_H_BP     = 220;
    localparam int HD720_V_ACTIVE = 720;
    localparam int HD720_V_FP     = 5;
    localparam int HD720_V_SYNC   = 5;
    localparam int HD720_V_BP     = 20;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } lock_state_t;

    // Totals and window edges are carried in 13 bits so H_TOTAL=4096 / V_TOTAL=2048 still fit.
    function automatic logic [12:0] sum13(input int a, input int b, input int c, input int d);
        return 13'(a + b + c + d);
    endfunction

endpackage

// File: rtl/hd_timing_gen_if.sv
// HD timing bundle: control inputs from the system side, raster outputs toward the upsampler.
// master = timing generator, slave = consumer; no handshake, outputs are free-running levels/pulses.
interface hd_timing_gen_if;

    logic        i_enable;
    logic        i_lock_en;
    logic        i_frame_end;
    logic        o_hd_clk;
    logic        o_hd_hsync;
    logic        o_hd_vsync;
    logic        o_hd_de;
    logic [11:0] o_hd_x;
    logic [10:0] o_hd_y;
    logic        o_frame_start;

    modport master (
        input  i_enable, i_lock_en, i_frame_end,
        output o_hd_clk, o_hd_hsync, o_hd_vsync, o_hd_de, o_hd_x, o_hd_y, o_frame_start
    );

    modport slave (
        output i_enable, i_lock_en, i_frame_end,
        input  o_hd_clk, o_hd_hsync, o_hd_vsync, o_hd_de, o_hd_x, o_hd_y, o_frame_start
    );

endinterface

// File: rtl/hd_timing_gen_pix_en_div.sv
// Pixel-rate divider: pix_en is combinational on div==CLK_DIV-1, hd_clk registered one clk behind div.
// enable=0 freezes div and holds hd_clk; pix_en is forced low.
module pix_en_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic pix_en,
    output logic hd_clk
);

    localparam int              W        = $clog2(CLK_DIV);
    localparam logic [W-1:0]    DIV_LAST = W'(CLK_DIV - 1);
    localparam logic [W-1:0]    DIV_HALF = W'(CLK_DIV / 2);

    logic [W-1:0] div;

    assign pix_en = enable && (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= '0;
            hd_clk <= 1'b0;
        end else if (enable) begin
            div    <= pix_en ? '0 : div + W'(1);
            hd_clk <= (div < DIV_HALF);
        end
    end

endmodule

// File: rtl/hd_timing_gen.sv
// 720p raster timing generator with optional PAL genlock of the vertical counter; outputs lag counters by 1 clk.
// i_enable=0 freezes divider, counters and raster outputs; genlock capture keeps running.
module hd_timing_gen
    import hd_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = HD720_H_ACTIVE,
    parameter int   H_FP      = HD720_H_FP,
    parameter int   H_SYNC    = HD720_H_SYNC,
    parameter int   H_BP      = HD720_H_BP,
    parameter int   V_ACTIVE  = HD720_V_ACTIVE,
    parameter int   V_FP      = HD720_V_FP,
    parameter int   V_SYNC    = HD720_V_SYNC,
    parameter int   V_BP      = HD720_V_BP,
    parameter int   CLK_DIV   = 2,
    parameter int   LOCK_LINE = 0,
    parameter logic SYNC_POL  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    hd_timing_gen_if.master hd
);

    localparam logic [12:0] H_TOTAL  = sum13(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam logic [12:0] V_TOTAL  = sum13(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [12:0] H_ACT    = sum13(H_ACTIVE, 0, 0, 0);
    localparam logic [12:0] V_ACT    = sum13(V_ACTIVE, 0, 0, 0);
    localparam logic [12:0] HS_START = sum13(H_ACTIVE, H_FP, 0, 0);
    localparam logic [12:0] HS_END   = sum13(H_ACTIVE, H_FP, H_SYNC, 0);
    localparam logic [12:0] VS_START = sum13(V_ACTIVE, V_FP, 0, 0);
    localparam logic [12:0] VS_END   = sum13(V_ACTIVE, V_FP, V_SYNC, 0);
    localparam logic [10:0] LOCK_V   = 11'(LOCK_LINE);

    logic        pix_en;
    logic [11:0] h;
    logic [10:0] v;
    logic [12:0] h13;
    logic [12:0] v13;
    logic        h_last;
    logic        v_last;
    logic        line_wrap;
    logic        reload;
    logic        entered;
    lock_state_t lock_state;
    logic        lock_pend;

    pix_en_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (hd.i_enable),
        .pix_en (pix_en),
        .hd_clk (hd.o_hd_clk)
    );

    assign h13       = {1'b0, h};
    assign v13       = {2'b00, v};
    assign h_last    = (h13 == H_TOTAL - 13'd1);
    assign v_last    = (v13 == V_TOTAL - 13'd1);
    assign line_wrap = pix_en && h_last;
    assign reload    = line_wrap && lock_pend && hd.i_lock_en;

    // Pulses arriving while already pending are absorbed: one reload per pending period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state <= IDLE;
            lock_pend  <= 1'b0;
        end else begin
            case (lock_state)
                IDLE: begin
                    if (hd.i_frame_end && hd.i_lock_en) begin
                        lock_state <= PEND;
                        lock_pend  <= 1'b1;
                    end
                end
                PEND: begin
                    if (!hd.i_lock_en || line_wrap) begin
                        lock_state <= IDLE;
                        lock_pend  <= 1'b0;
                    end
                end
                default: begin
                    lock_state <= IDLE;
                    lock_pend  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h       <= '0;
            v       <= '0;
            entered <= 1'b0;
        end else begin
            entered <= 1'b0;
            if (pix_en) begin
                if (h_last) begin
                    h <= '0;
                    if (reload) begin
                        v       <= LOCK_V;
                        entered <= (LOCK_V == 11'd0);
                    end else if (v_last) begin
                        v       <= '0;
                        entered <= 1'b1;
                    end else begin
                        v <= v + 11'd1;
                    end
                end else begin
                    h <= h + 12'd1;
                end
            end
        end
    end

    // frame_start is not gated so a frame entry is never stretched or lost by i_enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd.o_hd_x        <= '0;
            hd.o_hd_y        <= '0;
            hd.o_hd_de       <= 1'b0;
            hd.o_hd_hsync    <= ~SYNC_POL;
            hd.o_hd_vsync    <= ~SYNC_POL;
            hd.o_frame_start <= 1'b0;
        end else begin
            hd.o_frame_start <= entered;
            if (hd.i_enable) begin
                hd.o_hd_x     <= h;
                hd.o_hd_y     <= v;
                hd.o_hd_de    <= (h13 < H_ACT) && (v13 < V_ACT);
                hd.o_hd_hsync <= ((h13 >= HS_START) && (h13 < HS_END)) ? SYNC_POL : ~SYNC_POL;
                hd.o_hd_vsync <= ((v13 >= VS_START) && (v13 < VS_END)) ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

endmodule

// File: tb/tb_hd_timing_gen.sv
// Directed bench: small raster for timing/genlock/enable/reset, wide-H and wide-V instances for 720p windows.
// Expected values are queued before each observation and popped when the DUT output is sampled.
module tb_hd_timing_gen;

    logic clk;
    logic rst_n;
    logic rst_w_n;

    hd_timing_gen_if if_s ();
    hd_timing_gen_if if_h ();
    hd_timing_gen_if if_v ();

    hd_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .LOCK_LINE(3), .SYNC_POL(1'b1)
    ) u_s (.clk(clk), .rst_n(rst_n), .hd(if_s));

    hd_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_h (.clk(clk), .rst_n(rst_w_n), .hd(if_h));

    hd_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .SYNC_POL(1'b0)
    ) u_v (.clk(clk), .rst_n(rst_w_n), .hd(if_v));

    typedef struct {
        string tag;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input int obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_empty observed=%0d expected=none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
        end
    endtask

    int n, de_px, hs_t, vs_t, hs_x, vs_y, line_t, extra, chg;
    int x0, y0, hc0, de0, hs0, vs0;
    int hmin, hmax, hcnt, hde, line_h, vmin, vmax, vcnt, vh, vde;

    initial begin
        rst_n   = 1'b0;
        rst_w_n = 1'b0;
        if_s.i_enable = 1'b1; if_s.i_lock_en = 1'b0; if_s.i_frame_end = 1'b0;
        if_h.i_enable = 1'b1; if_h.i_lock_en = 1'b0; if_h.i_frame_end = 1'b0;
        if_v.i_enable = 1'b1; if_v.i_lock_en = 1'b0; if_v.i_frame_end = 1'b0;
        repeat (3) tick();

        // reset state
        push("rst_x", 0);       check(int'(if_s.o_hd_x));
        push("rst_y", 0);       check(int'(if_s.o_hd_y));
        push("rst_de", 0);      check(int'(if_s.o_hd_de));
        push("rst_hd_clk", 0);  check(int'(if_s.o_hd_clk));
        push("rst_hsync", 0);   check(int'(if_s.o_hd_hsync));
        push("rst_vsync", 0);   check(int'(if_s.o_hd_vsync));
        push("rst_fs", 0);      check(int'(if_s.o_frame_start));
        push("rst_hsync_pol0", 1); check(int'(if_v.o_hd_hsync));
        push("rst_vsync_pol0", 1); check(int'(if_v.o_hd_vsync));

        // small raster: 14 px x 7 lines x 2 clk = 196 clk per frame
        rst_n = 1'b1;
        n = 0;
        while (!if_s.o_frame_start && n < 400) begin tick(); n++; end
        push("first_fs_clk", 197); check(n);
        push("fs_x", 0); check(int'(if_s.o_hd_x));
        push("fs_y", 0); check(int'(if_s.o_hd_y));

        de_px = 0; hs_t = 0; vs_t = 0; hs_x = -1; vs_y = -1; line_t = -1; extra = 0;
        for (int i = 0; i < 196; i++) begin
            if (if_s.o_hd_de && if_s.o_hd_clk) de_px++;
            if (if_s.o_hd_hsync) begin hs_t++; if (hs_x < 0) hs_x = int'(if_s.o_hd_x); end
            if (if_s.o_hd_vsync) begin vs_t++; if (vs_y < 0) vs_y = int'(if_s.o_hd_y); end
            if (line_t < 0 && if_s.o_hd_y == 11'd1) line_t = i;
            if (i > 0 && if_s.o_frame_start) extra++;
            tick();
        end
        push("de_pixels", 32);    check(de_px);
        push("hsync_clk", 28);    check(hs_t);
        push("hsync_first_x", 10); check(hs_x);
        push("vsync_clk", 28);    check(vs_t);
        push("vsync_first_y", 5); check(vs_y);
        push("line_period", 28);  check(line_t);
        push("fs_extra", 0);      check(extra);
        push("fs_period", 1);     check(int'(if_s.o_frame_start));
        tick();
        push("fs_one_cycle", 0);  check(int'(if_s.o_frame_start));

        // genlock: pulse at v=1 h=5, second pulse while pending
        if_s.i_lock_en = 1'b1;
        n = 0;
        while (!(if_s.o_hd_y == 11'd1 && if_s.o_hd_x == 12'd5) && n < 200) begin tick(); n++; end
        if_s.i_frame_end = 1'b1; tick(); if_s.i_frame_end = 1'b0;
        repeat (4) tick();
        if_s.i_frame_end = 1'b1; tick(); if_s.i_frame_end = 1'b0;
        push("lock_reload_y", 3);
        n = 0;
        while (if_s.o_hd_y == 11'd1 && n < 100) begin tick(); n++; end
        check(int'(if_s.o_hd_y));
        push("lock_single_reload", 4);
        n = 0;
        while (if_s.o_hd_y == 11'd3 && n < 100) begin tick(); n++; end
        check(int'(if_s.o_hd_y));

        // lock_en falling while pending cancels the reload
        if_s.i_frame_end = 1'b1; tick(); if_s.i_frame_end = 1'b0;
        tick(); if_s.i_lock_en = 1'b0;
        push("lock_drop_y", 5);
        n = 0;
        while (if_s.o_hd_y == 11'd4 && n < 100) begin tick(); n++; end
        check(int'(if_s.o_hd_y));

        // enable gating mid-line; genlock still captures a pulse while frozen
        n = 0;
        while (!(if_s.o_hd_y == 11'd5 && if_s.o_hd_x == 12'd6) && n < 100) begin tick(); n++; end
        x0 = int'(if_s.o_hd_x); y0 = int'(if_s.o_hd_y); hc0 = int'(if_s.o_hd_clk);
        de0 = int'(if_s.o_hd_de); hs0 = int'(if_s.o_hd_hsync); vs0 = int'(if_s.o_hd_vsync);
        if_s.i_enable  = 1'b0;
        if_s.i_lock_en = 1'b1;
        chg = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 3) if_s.i_frame_end = 1'b1;
            if (i == 4) if_s.i_frame_end = 1'b0;
            if (int'(if_s.o_hd_x) != x0 || int'(if_s.o_hd_y) != y0 || int'(if_s.o_hd_clk) != hc0 ||
                int'(if_s.o_hd_de) != de0 || int'(if_s.o_hd_hsync) != hs0 || int'(if_s.o_hd_vsync) != vs0)
                chg++;
        end
        push("freeze_changes", 0); check(chg);
        push("frozen_x", 6);       check(x0);
        if_s.i_enable = 1'b1;
        tick();
        push("resume_x_hold", 6);  check(int'(if_s.o_hd_x));
        tick();
        push("resume_x_next", 7);  check(int'(if_s.o_hd_x));
        push("capture_while_frozen_y", 3);
        n = 0;
        while (if_s.o_hd_y == 11'd5 && n < 100) begin tick(); n++; end
        check(int'(if_s.o_hd_y));
        if_s.i_lock_en = 1'b0;

        // async reset at h=5 v=2, away from any clock edge
        n = 0;
        while (!(if_s.o_hd_y == 11'd2 && if_s.o_hd_x == 12'd5) && n < 400) begin tick(); n++; end
        push("pre_rst_de", 1); check(int'(if_s.o_hd_de));
        #2;
        rst_n = 1'b0;
        #1;
        push("arst_x", 0);      check(int'(if_s.o_hd_x));
        push("arst_y", 0);      check(int'(if_s.o_hd_y));
        push("arst_de", 0);     check(int'(if_s.o_hd_de));
        push("arst_hd_clk", 0); check(int'(if_s.o_hd_clk));
        push("arst_hsync", 0);  check(int'(if_s.o_hd_hsync));
        repeat (2) tick();
        rst_n = 1'b1;
        push("rel_hd_clk_0", 0); check(int'(if_s.o_hd_clk));
        tick();
        push("rel_hd_clk_1", 1); check(int'(if_s.o_hd_clk));
        tick();
        push("rel_x_2clk", 0);   check(int'(if_s.o_hd_x));
        tick();
        push("rel_x_3clk", 1);   check(int'(if_s.o_hd_x));

        // 720p horizontal (u_h) and vertical (u_v, SYNC_POL=0) windows
        rst_w_n = 1'b1;
        hmin = 99999; hmax = -1; hcnt = 0; hde = 0; line_h = -1;
        vmin = 99999; vmax = -1; vcnt = 0; vh = 0; vde = 0;
        for (int t = 0; t <= 21000; t++) begin
            if (if_h.o_hd_y == 11'd0) begin
                if (if_h.o_hd_hsync) begin
                    hcnt++;
                    if (int'(if_h.o_hd_x) < hmin) hmin = int'(if_h.o_hd_x);
                    if (int'(if_h.o_hd_x) > hmax) hmax = int'(if_h.o_hd_x);
                end
                if (if_h.o_hd_de && if_h.o_hd_clk) hde++;
            end
            if (line_h < 0 && if_h.o_hd_y == 11'd1) line_h = t;
            if (!if_v.o_hd_vsync) begin
                vcnt++;
                if (int'(if_v.o_hd_y) < vmin) vmin = int'(if_v.o_hd_y);
                if (int'(if_v.o_hd_y) > vmax) vmax = int'(if_v.o_hd_y);
            end
            if (!if_v.o_hd_hsync) vh++;
            if (if_v.o_hd_de && if_v.o_hd_clk) vde++;
            tick();
        end
        push("hd_hsync_min_x", 1390); check(hmin);
        push("hd_hsync_max_x", 1429); check(hmax);
        push("hd_hsync_clk", 80);     check(hcnt);
        push("hd_de_pixels_line", 1280); check(hde);
        push("hd_line_period", 3301); check(line_h);
        push("hd_vsync_min_y", 725);  check(vmin);
        push("hd_vsync_max_y", 729);  check(vmax);
        push("hd_vsync_clk", 140);    check(vcnt);
        push("pol0_hsync_low_clk", 3000); check(vh);
        push("hd_de_pixels_frame", 5760); check(vde);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
